// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: data widths, ALU op codes
// and the arbiter state encoding.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
   localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [OP_W-1:0] ALU_XNOR = 4'b0101;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic int wrap_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle between the requesters, the shared ALU
// and the arbiter. The arbiter side uses the slave modport.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
);
   import alu_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [NUM_REQ*OP_W-1:0]   req_op;

   logic [DATA_W-1:0]         alu_a;
   logic [DATA_W-1:0]         alu_b;
   logic [OP_W-1:0]           alu_ctrl;
   logic [DATA_W-1:0]         alu_out;

   logic                      resp_valid;
   logic                      resp_ready;
   logic [DATA_W-1:0]         resp_data;
   logic [ID_W-1:0]           resp_id;
   logic                      busy;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_out, resp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl, resp_valid, resp_data, resp_id, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_out, resp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl, resp_valid, resp_data, resp_id, busy
   );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// returned both one-hot and as an index.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_valid
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!any_valid && valid[cand]) begin
            any_valid   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// registered operands, one-cycle execute, then a held, ID-tagged response.
module alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);
   import alu_pkg::*;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   resp_id_q, resp_id_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [OP_W-1:0]   alu_ctrl_q, alu_ctrl_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_valid_q, resp_valid_d;

   logic [NUM_REQ-1:0] grant_onehot;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;

   logic [DATA_W-1:0] req_a_arr  [NUM_REQ];
   logic [DATA_W-1:0] req_b_arr  [NUM_REQ];
   logic [OP_W-1:0]   req_op_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_a_arr[i]  = bus.req_a[i*DATA_W +: DATA_W];
      assign req_b_arr[i]  = bus.req_b[i*DATA_W +: DATA_W];
      assign req_op_arr[i] = bus.req_op[i*OP_W +: OP_W];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ID_W)
   ) u_picker (
      .valid     (bus.req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant_onehot),
      .grant_idx (grant_idx),
      .any_valid (grant_any)
   );

   // Ready is only offered in IDLE, so a grant there is always a handshake.
   assign bus.req_ready  = (rst_n && state_q == ST_IDLE) ? grant_onehot : '0;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_ctrl   = alu_ctrl_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_id    = resp_id_q;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      resp_valid_d = resp_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               alu_a_d    = req_a_arr[grant_idx];
               alu_b_d    = req_b_arr[grant_idx];
               alu_ctrl_d = req_op_arr[grant_idx];
               id_d       = grant_idx;
               rr_ptr_d   = ID_W'(wrap_next(int'(grant_idx), NUM_REQ));
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            resp_data_d  = bus.alu_out;
            resp_id_d    = id_q;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         resp_data_q  <= '0;
         resp_id_q    <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
         resp_valid_q <= resp_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with two requesters: a table of single operations,
// hand-built multi-cycle sequences and a randomized run against a
// transaction-level model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural stand-in for the shared ALU; the compare is unsigned.
   function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~(a ^ b);
         4'd6:    return (a < b) ? 16'h0001 : 16'h0000;
         default: return a + b;
      endcase
   endfunction

   assign bus.alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);

   typedef struct {
      int          req;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs [12];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clearInputs();
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_op     = '0;
      bus.resp_ready = 1'b0;
   endtask

   task automatic setReq(input int r, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
      bus.req_a  = (bus.req_a  & ~(32'h0000FFFF << (16*r))) | (32'(a) << (16*r));
      bus.req_b  = (bus.req_b  & ~(32'h0000FFFF << (16*r))) | (32'(b) << (16*r));
      bus.req_op = (bus.req_op & ~(8'h0F << (4*r)))         | (8'(op) << (4*r));
   endtask

   task automatic doReset();
      @(negedge clk);
      clearInputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One isolated operation: grant, execute, response, return to idle.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      clearInputs();
      setReq(v.req, v.a, v.b, v.op);
      bus.req_valid[v.req] = 1'b1;
      #1;
      checkOutput("vec_grant", 32'(bus.req_ready), 32'(1 << v.req));
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checkOutput("vec_exec_busy", 32'(bus.busy), 32'd1);
      checkOutput("vec_exec_rvalid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("vec_rvalid", 32'(bus.resp_valid), 32'd1);
      checkOutput("vec_data", 32'(bus.resp_data), 32'(v.exp_data));
      checkOutput("vec_id", 32'(bus.resp_id), 32'(v.req));
      bus.resp_ready = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("vec_done_rvalid", 32'(bus.resp_valid), 32'd0);
      checkOutput("vec_done_busy", 32'(bus.busy), 32'd0);
      bus.resp_ready = 1'b0;
   endtask

   function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         int c;
         c = (p + k) % NUM_REQ;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{0,  16'h0005, 16'h0003, 4'b0001, 16'h0002};
      vecs[1]  = '{1,  16'h00FF, 16'h0001, 4'b0000, 16'h0100};
      vecs[2]  = '{0,  16'h0001, 16'h0002, 4'b0110, 16'h0001};
      vecs[3]  = '{1,  16'hFFFF, 16'h0001, 4'b0000, 16'h0000};
      vecs[4]  = '{0,  16'h0010, 16'h0020, 4'b1111, 16'h0030};
      vecs[5]  = '{1,  16'hF0F0, 16'hFF00, 4'b0010, 16'hF000};
      vecs[6]  = '{0,  16'h00F0, 16'h0F00, 4'b0011, 16'h0FF0};
      vecs[7]  = '{1,  16'hAAAA, 16'hFFFF, 4'b0100, 16'h5555};
      vecs[8]  = '{0,  16'h1234, 16'h1234, 4'b0101, 16'hFFFF};
      vecs[9]  = '{1,  16'h0002, 16'h0001, 4'b0110, 16'h0000};
      vecs[10] = '{1,  16'h0000, 16'h0001, 4'b0001, 16'hFFFF};
      vecs[11] = '{0,  16'h0007, 16'h0008, 4'b0111, 16'h000F};

      // Reset state, with requests already pending while in reset.
      rst_n = 1'b0;
      clearInputs();
      bus.req_valid = 2'b11;
      setReq(0, 16'h1111, 16'h2222, 4'h3);
      setReq(1, 16'h3333, 16'h4444, 4'h4);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
      checkOutput("rst_alu_b", 32'(bus.alu_b), 32'd0);
      checkOutput("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      checkOutput("rst_resp_data", 32'(bus.resp_data), 32'd0);
      checkOutput("rst_resp_id", 32'(bus.resp_id), 32'd0);
      clearInputs();
      rst_n = 1'b1;

      // Round robin from rr_ptr=0 with both requesters always valid.
      @(negedge clk);
      setReq(0, 16'h00FF, 16'h0001, 4'b0000);
      setReq(1, 16'h00FF, 16'h0002, 4'b0000);
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #1;
         checkOutput("rr_grant", 32'(bus.req_ready), 32'(1 << (n % 2)));
         @(negedge clk);
         #1;
         checkOutput("rr_exec_ready", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
         #1;
         checkOutput("rr_rvalid", 32'(bus.resp_valid), 32'd1);
         checkOutput("rr_id", 32'(bus.resp_id), 32'(n % 2));
         checkOutput("rr_data", 32'(bus.resp_data), (n % 2 == 0) ? 32'h0100 : 32'h0101);
         checkOutput("rr_resp_ready", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      clearInputs();

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Backpressure: response held for five cycles with another request waiting.
      @(negedge clk);
      clearInputs();
      setReq(0, 16'h1234, 16'h0F0F, 4'b0010);
      setReq(1, 16'h0001, 16'h0001, 4'b0000);
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b10;
      @(negedge clk);
      for (int n = 0; n < 5; n++) begin
         #1;
         checkOutput("bp_rvalid", 32'(bus.resp_valid), 32'd1);
         checkOutput("bp_data", 32'(bus.resp_data), 32'h0204);
         checkOutput("bp_id", 32'(bus.resp_id), 32'd0);
         checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      #1;
      checkOutput("bp_accept_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_accept_rvalid", 32'(bus.resp_valid), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("bp_idle_rvalid", 32'(bus.resp_valid), 32'd0);
      checkOutput("bp_idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("bp_idle_grant", 32'(bus.req_ready), 32'b10);
      clearInputs();

      // Reset during EXEC: immediate clear, then priority restarts at requester 0.
      doReset();
      @(negedge clk);
      setReq(0, 16'h0001, 16'h0002, 4'b0110);
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      checkOutput("mid_busy_before", 32'(bus.busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rvalid", 32'(bus.resp_valid), 32'd0);
      checkOutput("mid_busy", 32'(bus.busy), 32'd0);
      checkOutput("mid_alu_a", 32'(bus.alu_a), 32'd0);
      checkOutput("mid_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      checkOutput("mid_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      setReq(1, 16'h0010, 16'h0020, 4'b1111);
      bus.req_valid = 2'b11;
      #1;
      checkOutput("post_rst_ptr", 32'(bus.req_ready), 32'b01);
      bus.req_valid = 2'b10;
      #1;
      checkOutput("post_rst_grant1", 32'(bus.req_ready), 32'b10);
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      #1;
      checkOutput("post_rst_rvalid", 32'(bus.resp_valid), 32'd1);
      checkOutput("post_rst_data", 32'(bus.resp_data), 32'h0030);
      checkOutput("post_rst_id", 32'(bus.resp_id), 32'd1);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      clearInputs();

      // Randomized traffic against a transaction-level model.
      doReset();
      begin
         int          ptr = 0;
         bit          outstanding = 0;
         int          age = 0;
         logic [15:0] exp_data = '0;
         int          exp_id = 0;
         int          g;
         for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.req_valid  = 2'($urandom);
            bus.req_a      = $urandom;
            bus.req_b      = $urandom;
            bus.req_op     = 8'($urandom_range(0, 255));
            bus.resp_ready = ($urandom_range(0, 9) < 7);
            #1;
            g = outstanding ? -1 : pick(bus.req_valid, ptr);
            checkOutput("rnd_req_ready", 32'(bus.req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
            checkOutput("rnd_busy", 32'(bus.busy), 32'(outstanding));
            checkOutput("rnd_rvalid", 32'(bus.resp_valid), 32'(outstanding && age >= 2));
            if (outstanding && age >= 2) begin
               checkOutput("rnd_data", 32'(bus.resp_data), 32'(exp_data));
               checkOutput("rnd_id", 32'(bus.resp_id), 32'(exp_id));
            end
            if (outstanding) begin
               if (age >= 2 && bus.resp_ready) outstanding = 0;
               else age++;
            end else if (g >= 0) begin
               outstanding = 1;
               age         = 1;
               exp_id      = g;
               exp_data    = alu_fn(16'(bus.req_a >> (16*g)), 16'(bus.req_b >> (16*g)),
                                    4'(bus.req_op >> (4*g)));
               ptr         = (g + 1) % NUM_REQ;
            end
         end
      end
      clearInputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
